// File: rtl/reset_sequencer.sv
// PLL-lock driven reset sequencer: PHY hardware reset pulse, PHY settle wait, then system reset release.
// Optional lock-loss counter enabled by defining RESET_SEQUENCER_LOCK_COUNT_EN.
module reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int PHY_RST_CYCLES     = 250000,
    parameter int PHY_WAIT_CYCLES    = 25000,
    parameter int CNT_W              = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    input  logic       sw_reset,
    output logic       sys_rst,
    output logic       phy_rst_n,
    output logic       ready,
    output logic [7:0] lock_loss_count
);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        PHY_RST   = 3'd2,
        PHY_WAIT  = 3'd3,
        RUN       = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRST_LAST = CNT_W'(PHY_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(PHY_WAIT_CYCLES - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             sync1_r;
    logic             sync2_r;
    logic             locked_s;
    logic             sys_rst_nxt_s;
    logic             phy_rst_n_nxt_s;
    logic             ready_nxt_s;

    assign locked_s = sync2_r;

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= locked;
            sync2_r <= sync1_r;
        end
    end

    // State, counter and registered outputs all advance on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= WAIT_LOCK;
            cnt_r     <= '0;
            sys_rst   <= 1'b1;
            phy_rst_n <= 1'b0;
            ready     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            sys_rst   <= sys_rst_nxt_s;
            phy_rst_n <= phy_rst_n_nxt_s;
            ready     <= ready_nxt_s;
        end
    end

    // Next state, counter and output values; lock loss outranks sw_reset.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        sys_rst_nxt_s   = 1'b1;
        phy_rst_n_nxt_s = 1'b0;
        ready_nxt_s     = 1'b0;
        case (state_r)
            WAIT_LOCK: begin
                cnt_nxt_s = '0;
                if (locked_s) begin
                    state_nxt_s = STABLE;
                end else begin
                    state_nxt_s = WAIT_LOCK;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_nxt_s = WAIT_LOCK;
                    cnt_nxt_s   = '0;
                end else if (cnt_r == LOCK_LAST) begin
                    state_nxt_s = PHY_RST;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = STABLE;
                end
            end
            PHY_RST: begin
                if (!locked_s) begin
                    state_nxt_s = WAIT_LOCK;
                    cnt_nxt_s   = '0;
                end else if (cnt_r == PRST_LAST) begin
                    state_nxt_s     = PHY_WAIT;
                    cnt_nxt_s       = '0;
                    phy_rst_n_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = PHY_RST;
                end
            end
            PHY_WAIT: begin
                phy_rst_n_nxt_s = 1'b1;
                if (!locked_s) begin
                    state_nxt_s     = WAIT_LOCK;
                    cnt_nxt_s       = '0;
                    phy_rst_n_nxt_s = 1'b0;
                end else if (cnt_r == WAIT_LAST) begin
                    state_nxt_s   = RUN;
                    cnt_nxt_s     = '0;
                    sys_rst_nxt_s = 1'b0;
                    ready_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = PHY_WAIT;
                end
            end
            RUN: begin
                cnt_nxt_s = '0;
                if (!locked_s) begin
                    state_nxt_s = WAIT_LOCK;
                end else if (sw_reset) begin
                    state_nxt_s = PHY_RST;
                end else begin
                    state_nxt_s     = RUN;
                    sys_rst_nxt_s   = 1'b0;
                    phy_rst_n_nxt_s = 1'b1;
                    ready_nxt_s     = 1'b1;
                end
            end
            default: begin
                state_nxt_s = WAIT_LOCK;
                cnt_nxt_s   = '0;
            end
        endcase
    end

`ifdef RESET_SEQUENCER_LOCK_COUNT_EN
    logic [7:0] loss_cnt_r;
    logic       loss_s;

    // Only losses after the PHY sequence has started count; STABLE dropouts are treated as lock still settling.
    assign loss_s = !locked_s && ((state_r == PHY_RST) || (state_r == PHY_WAIT) || (state_r == RUN));

    // Saturating lock-loss counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loss_cnt_r <= 8'd0;
        end else if (loss_s && (loss_cnt_r != 8'hFF)) begin
            loss_cnt_r <= loss_cnt_r + 8'd1;
        end else begin
            loss_cnt_r <= loss_cnt_r;
        end
    end

    assign lock_loss_count = loss_cnt_r;
`else
    assign lock_loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (L=8, P=5, W=3) with an expected-value scoreboard queue.
module tb_reset_sequencer;

    logic       clk;
    logic       rst;
    logic       locked;
    logic       sw_reset;
    logic       sys_rst;
    logic       phy_rst_n;
    logic       ready;
    logic [7:0] lock_loss_count;

    typedef struct {
        string      tag;
        logic       sys;
        logic       phy;
        logic       rdy;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   tests;
    int   fails;
    int   nloss;

    reset_sequencer #(
        .LOCK_STABLE_CYCLES(8),
        .PHY_RST_CYCLES    (5),
        .PHY_WAIT_CYCLES   (3),
        .CNT_W             (20)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .locked         (locked),
        .sw_reset       (sw_reset),
        .sys_rst        (sys_rst),
        .phy_rst_n      (phy_rst_n),
        .ready          (ready),
        .lock_loss_count(lock_loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_count(input int n);
`ifdef RESET_SEQUENCER_LOCK_COUNT_EN
        return (n > 255) ? 8'd255 : 8'(n);
`else
        return 8'd0;
`endif
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input string tag, input logic s, input logic p, input logic r);
        exp_t e;
        e.tag = tag;
        e.sys = s;
        e.phy = p;
        e.rdy = r;
        e.cnt = exp_count(nloss);
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            cmp({e.tag, ".sys_rst"},   {7'd0, sys_rst},   {7'd0, e.sys});
            cmp({e.tag, ".phy_rst_n"}, {7'd0, phy_rst_n}, {7'd0, e.phy});
            cmp({e.tag, ".ready"},     {7'd0, ready},     {7'd0, e.rdy});
            cmp({e.tag, ".count"},     lock_loss_count,   e.cnt);
        end
    endtask

    // Checks the full lock-to-run timeline; call just after locked is driven high before edge k.
    task automatic seq_check(input string tag);
        for (int t = 1; t <= 20; t++) begin
            push(tag, (t < 19), (t >= 16), (t >= 19));
            tick();
            check();
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        nloss    = 0;
        rst      = 1'b0;
        locked   = 1'b0;
        sw_reset = 1'b0;

        // Asynchronous reset takes effect before any clock edge
        #1 rst = 1'b1;
        #1;
        push("reset_async", 1'b1, 1'b0, 1'b0);
        check();
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < 100; i++) begin
            push("no_lock", 1'b1, 1'b0, 1'b0);
            tick();
            check();
        end

        // One-sample dropout while STABLE at cnt=5
        locked = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            push("stable_pre", 1'b1, 1'b0, 1'b0);
            tick();
            check();
        end
        locked = 1'b0;
        push("stable_glitch", 1'b1, 1'b0, 1'b0);
        tick();
        check();
        locked = 1'b1;
        seq_check("relock");

        // Lock loss in RUN
        locked = 1'b0;
        push("loss_m0", 1'b0, 1'b1, 1'b1);
        tick();
        check();
        push("loss_m1", 1'b0, 1'b1, 1'b1);
        tick();
        check();
        nloss++;
        push("loss_m2", 1'b1, 1'b0, 1'b0);
        tick();
        check();
        locked = 1'b1;
        seq_check("relock_after_loss");

        for (int i = 0; i < 300; i++) begin
            locked = 1'b0;
            tick();
            tick();
            nloss++;
            push("loss_sat", 1'b1, 1'b0, 1'b0);
            tick();
            check();
            locked = 1'b1;
            for (int j = 0; j < 19; j++) tick();
        end
        push("run_after_sat", 1'b0, 1'b1, 1'b1);
        tick();
        check();

        // sw_reset in RUN, then a second pulse while in PHY_WAIT is ignored
        for (int t = 1; t <= 10; t++) begin
            sw_reset = (t == 1) || (t == 7);
            push("sw_reset", (t < 9), (t >= 6), (t >= 9));
            tick();
            sw_reset = 1'b0;
            check();
        end

        // Asynchronous reset mid PHY_WAIT
        sw_reset = 1'b1;
        tick();
        sw_reset = 1'b0;
        for (int t = 0; t < 4; t++) tick();
        push("phy_wait", 1'b1, 1'b1, 1'b0);
        tick();
        check();
        #2 rst = 1'b1;
        #1;
        nloss = 0;
        push("reset_mid_wait", 1'b1, 1'b0, 1'b0);
        check();
        tick();
        rst = 1'b0;
        seq_check("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Consumes the ECP5 PLL `locked` output and produces the system reset and the Ethernet PHY hardware reset in the PLL output clock domain. It waits for `locked` to be stable, pulses the PHY reset, waits out the PHY post-reset settle time, then releases the system reset. If lock is lost, it re-sequences automatically. It sits directly downstream of the clock PLL and upstream of the MAC/MDIO logic.

Parameters:
- LOCK_STABLE_CYCLES, 1024: cycles `locked` must stay high before sequencing continues (≥1).
- PHY_RST_CYCLES, 250000: cycles `phy_rst_n` is held low (≥1).
- PHY_WAIT_CYCLES, 25000: cycles after `phy_rst_n` rises before `sys_rst` is released (≥1).
- CNT_W, 20: sequencing counter width; must hold max(param)-1.

Ports:
- clk  input  1  PLL output clock; all logic is in this domain.
- rst  input  1  asynchronous, active-high reset.
- locked  input  1  PLL lock; asynchronous to `clk`.
- sw_reset  input  1  single-cycle request to re-pulse PHY and system reset.
- sys_rst  output  1  active-high system reset, registered.
- phy_rst_n  output  1  active-low PHY hardware reset, registered.
- ready  output  1  high only in RUN, registered.
- lock_loss_count  output  8  saturating count of lock losses after stable lock.

Behaviour:
- Reset values (immediate on `rst` rising, no clock needed):
  - state=WAIT_LOCK, cnt=0
  - sync flops=0
  - sys_rst=1, phy_rst_n=0, ready=0, lock_loss_count=0
- `locked` passes through a 2-flop synchroniser to give `locked_s`. Let edge k be the first edge that samples `locked` high. Then `locked_s`=1 after edge k+1.
- All outputs are registered and updated on the same edge as the state.
- WAIT_LOCK:
  - Outputs: sys_rst=1, phy_rst_n=0, ready=0.
  - If `locked_s`: go to STABLE, cnt=0.
- STABLE:
  - If `!locked_s`: go to WAIT_LOCK, cnt=0. Not counted as a loss.
  - Else if cnt==LOCK_STABLE_CYCLES-1: go to PHY_RST, cnt=0.
  - Else cnt++.
- PHY_RST:
  - phy_rst_n=0.
  - At cnt==PHY_RST_CYCLES-1: go to PHY_WAIT, cnt=0, phy_rst_n←1.
- PHY_WAIT:
  - At cnt==PHY_WAIT_CYCLES-1: go to RUN, sys_rst←0, ready←1.
- RUN:
  - Holds sys_rst=0, phy_rst_n=1, ready=1.
  - If `sw_reset`: go to PHY_RST, cnt=0, sys_rst←1, phy_rst_n←0, ready←0.
- Resulting timing from edge k:
  - STABLE is entered at edge k+2.
  - phy_rst_n rises at edge k+2+L+P.
  - sys_rst falls and ready rises at edge k+2+L+P+W.
- Lock loss in PHY_RST, PHY_WAIT or RUN:
  - Go to WAIT_LOCK, cnt=0, with sys_rst=1, phy_rst_n=0, ready=0.
  - lock_loss_count++, saturating at 255.
  - Outputs assert 2 edges after the edge that first samples `locked` low.
- Simultaneous `!locked_s` and `sw_reset` in RUN: lock loss wins.
- `sw_reset` is ignored in every state except RUN. It is never queued.
- Reset mid-sequence aborts to the reset values. There is no partial resume.
- A counter terminal compare must not wrap. cnt is cleared on every state change.

Optional Feature:
- Macro: RESET_SEQUENCER_LOCK_COUNT_EN.
- Defined: lock_loss_count behaves as above.
- Undefined:
  - The counter register is not built and lock_loss_count is tied to 8'd0.
  - All other behaviour is identical.

Test Plan:
- Bench uses L=8, P=5, W=3. k is the first edge sampling `locked`=1.
- Reset asserted then released, `locked`=0 held for 100 cycles -> sys_rst=1, phy_rst_n=0, ready=0, count=0 throughout.
- `locked` rises (edge k) -> phy_rst_n=0 until edge k+15, 1 from k+15; sys_rst=1 until edge k+18, then sys_rst=0, ready=1.
- `locked` low for one sample while in STABLE at cnt=5 -> returns to WAIT_LOCK, count stays 0. Timing restarts from the re-rise: phy_rst_n at k'+15, ready at k'+18.
- In RUN, `locked` drops (sampled at edge m) -> sys_rst=1, phy_rst_n=0, ready=0 at edge m+2; count=1. Repeating 300 losses -> count saturates at 255 (0 when macro is off).
- One-cycle `sw_reset` in RUN -> phy_rst_n low for 5 cycles, sys_rst=1 for 8 cycles, then ready=1. `sw_reset` in PHY_WAIT -> no effect.
- `rst` asserted asynchronously mid-PHY_WAIT -> outputs return to reset values before the next `clk` edge; full sequence repeats after release.
